// File: rtl/ddr_wr_seq_if.sv
// ddr_wr_seq_if -- AXI4 write-address, write-data and write-response
// channel bundle between the write sequencer and the memory side.
//   master modport: sequencer side (drives aw*/w*/bready)
//   slave  modport: memory side   (drives awready/wready/bvalid)
interface ddr_wr_seq_if;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        wlast;
  logic        bvalid;
  logic        bready;

  modport master (
    output awaddr, awlen, awvalid, wdata, wstrb, wvalid, wlast, bready,
    input  awready, wready, bvalid
  );

  modport slave (
    input  awaddr, awlen, awvalid, wdata, wstrb, wvalid, wlast, bready,
    output awready, wready, bvalid
  );
endinterface

// File: rtl/ddr_wr_seq.sv
// ddr_wr_seq -- buffers a 32-bit word stream in a FIFO and writes it to
// memory as a sequence of AXI4 INCR bursts of up to BURST_LEN beats.
// Ports:
//   axi_aclk, axi_aresetn   clock, synchronous active-low reset
//   start/base_addr/num_words  transfer request (accepted only when idle)
//   busy, done              transfer status / one-cycle completion pulse
//   s_data/s_valid/s_ready  input word stream into the FIFO
//   axi                     AXI write channels (ddr_wr_seq_if.master)
// Build option: define DDR_WR_SEQ_4K_BOUNDARY_EN to split bursts so none
// crosses a 4 KB address boundary.
module ddr_wr_seq #(
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic         axi_aclk,
  input  logic         axi_aresetn,
  input  logic         start,
  input  logic [31:0]  base_addr,
  input  logic [23:0]  num_words,
  output logic         busy,
  output logic         done,
  input  logic [31:0]  s_data,
  input  logic         s_valid,
  output logic         s_ready,
  ddr_wr_seq_if.master axi
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, WAIT_DATA, ADDR, DATA, RESP} state_t;
  state_t state, state_nxt;

  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, count;
  logic        push, pop, full;
  logic [31:0] addr;
  logic [23:0] remaining;
  logic [8:0]  beats, beat_cnt;
  logic        start_ok, last_beat, last_burst;

  // FIFO: pointers carry one extra wrap bit so count spans 0..FIFO_DEPTH.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == DEPTH_W);
  // Gating with reset keeps s_ready low during reset yet high right after.
  assign s_ready = axi_aresetn & ~full;
  assign push    = s_valid & s_ready;
  assign pop     = (state == DATA) & axi.wready;

  // The done cycle is still busy, so a start there is ignored.
  assign start_ok = start & (state == IDLE) & ~busy;

  always_ff @(posedge axi_aclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_data;
  end

`ifdef DDR_WR_SEQ_4K_BOUNDARY_EN
  logic [12:0] room;
  assign room = (13'd4096 - {1'b0, addr[11:0]}) >> 2;
`endif

  // Burst size is derived from the live address/remaining registers; they
  // only change on the response handshake, so it is stable for a burst.
  always_comb begin
    if (remaining > 24'(BURST_LEN)) beats = 9'(BURST_LEN);
    else                            beats = remaining[8:0];
`ifdef DDR_WR_SEQ_4K_BOUNDARY_EN
    if (13'(beats) > room) beats = room[8:0];
`endif
  end

  assign last_beat  = (beat_cnt == beats - 9'd1);
  assign last_burst = (remaining == {15'b0, beats});

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start_ok && num_words != '0) state_nxt = WAIT_DATA;
      WAIT_DATA: if (32'(count) >= 32'(beats))    state_nxt = ADDR;
      ADDR:      if (axi.awready)                 state_nxt = DATA;
      DATA:      if (axi.wready && last_beat)     state_nxt = RESP;
      RESP:      if (axi.bvalid)                  state_nxt = last_burst ? IDLE : WAIT_DATA;
      default:                                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    axi.awaddr  = addr;
    axi.awvalid = 1'b0;
    axi.awlen   = '0;
    axi.wvalid  = 1'b0;
    axi.wdata   = '0;
    axi.wstrb   = '0;
    axi.wlast   = 1'b0;
    axi.bready  = 1'b0;
    case (state)
      ADDR: begin
        axi.awvalid = 1'b1;
        axi.awlen   = 8'(beats - 9'd1);
      end
      DATA: begin
        axi.wvalid = 1'b1;
        axi.wdata  = mem[rd_ptr[AW-1:0]];
        axi.wstrb  = 4'hF;
        axi.wlast  = last_beat;
      end
      RESP:    axi.bready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      addr      <= '0;
      remaining <= '0;
      beat_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (state == ADDR)  beat_cnt <= '0;
      else if (pop)       beat_cnt <= beat_cnt + 9'd1;

      if (done) busy <= 1'b0;
      if (start_ok) begin
        addr      <= base_addr & 32'hFFFF_FFFC;
        remaining <= num_words;
        busy      <= (num_words != '0);
        done      <= (num_words == '0);
      end

      if (state == RESP && axi.bvalid) begin
        addr      <= addr + {21'b0, beats, 2'b00};
        remaining <= remaining - 24'(beats);
        done      <= last_burst;
      end
    end
  end

endmodule

// File: doc/ddr_wr_seq.md
DDR_WR_SEQ -- requirements
Module: ddr_wr_seq

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, beats per AXI burst (1..256).
REQ-002 SHALL have parameter FIFO_DEPTH, default 32, input FIFO words (power of 2, >= BURST_LEN).
REQ-003 axi_aclk  input  1  sole clock; all logic on rising edge.
REQ-004 axi_aresetn  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle transfer request.
REQ-006 base_addr  input  32  transfer byte address; bits [1:0] ignored.
REQ-007 num_words  input  24  transfer length in 32-bit words.
REQ-008 busy  output  1  transfer in progress.
REQ-009 done  output  1  one-cycle pulse on transfer completion.
REQ-010 s_data  input  32  stream word.
REQ-011 s_valid  input  1  stream word valid.
REQ-012 s_ready  output  1  FIFO can accept a word.
REQ-013 axi_awaddr, axi_awlen, axi_awvalid  output  32/8/1  write address channel.
REQ-014 axi_awready  input  1  address accepted.
REQ-015 axi_wdata, axi_wstrb, axi_wvalid, axi_wlast  output  32/4/1/1  write data channel.
REQ-016 axi_wready  input  1  beat accepted.
REQ-017 axi_bvalid  input  1  write response; axi_bready  output  1.

Function
REQ-018 start while idle SHALL latch base_addr (bits [1:0] forced 0) and num_words, and raise busy next cycle; start while busy SHALL be ignored.
REQ-019 num_words = 0 SHALL give a done pulse the cycle after start, with no AXI activity and busy staying low.
REQ-020 FIFO SHALL write on s_valid & s_ready; s_ready = !full, including while idle; beyond num_words, words SHALL remain queued for the next transfer.
REQ-021 FSM states SHALL be IDLE, WAIT_DATA, ADDR, DATA, RESP; IDLE->WAIT_DATA on accepted start.
REQ-022 beats = min(BURST_LEN, remaining words), further limited per REQ-033.
REQ-023 WAIT_DATA->ADDR when FIFO count >= beats, so wvalid never drops mid-burst.
REQ-024 ADDR: axi_awvalid=1, awaddr=current address, awlen=beats-1, held stable until awready; then ->DATA.
REQ-025 axi_wvalid SHALL NOT assert in the same cycle as axi_awvalid.
REQ-026 DATA: wvalid=1, wdata=FIFO head, wstrb=4'hF; pop on wvalid & wready; wlast on the final beat; after last accepted beat ->RESP.
REQ-027 RESP: axi_bready=1; on bvalid, address += beats*4 and remaining -= beats; then ->WAIT_DATA if remaining > 0, else ->IDLE with a done pulse the same cycle.
REQ-028 Address SHALL wrap modulo 2^32 without error.
REQ-029 busy SHALL be 1 from the cycle after accepted start until the cycle done pulses, inclusive of that cycle.

Reset
REQ-030 While axi_aresetn=0 at an edge: state IDLE, FIFO flushed, remaining=0; busy, done, axi_awvalid, axi_wvalid, axi_wlast, axi_bready = 0; awaddr, awlen, wdata = 0; s_ready = 0.
REQ-031 Reset mid-burst SHALL abandon the transfer without a done pulse; s_ready=1 from the first cycle after release.

Configuration
REQ-032 Macro DDR_WR_SEQ_4K_BOUNDARY_EN selects 4 KB boundary splitting.
REQ-033 When the macro is defined, beats SHALL also be limited to (4096 - addr[11:0])/4 so no burst crosses a 4 KB boundary; when undefined, no such limit applies.

Verification
REQ-034 base 0x0040_0000, num_words 40, stream continuous -> bursts (0x0040_0000, len 15), (0x0040_0040, len 15), (0x0040_0080, len 7); one done after third bvalid.
REQ-035 num_words 0 -> done the cycle after start; axi_awvalid stays 0; busy stays 0.
REQ-036 Stream 1 word every 3 cycles, num_words 16 -> awvalid rises only after 16 words are queued; wvalid stays continuously high for 16 beats with wready=1.
REQ-037 base 0x0000_0FF0, num_words 16 -> with macro: (0x0000_0FF0, len 3) then (0x0000_1000, len 11); without: single (0x0000_0FF0, len 15).
REQ-038 axi_aresetn low for 1 cycle at beat 5 of a burst -> all valids 0 next edge, no done; a new start of 8 words then completes normally.
REQ-039 Second start pulsed mid-transfer -> ignored; exactly one done and the original burst addresses.
